// File: rtl/booth4_seq_pp_accumulator.sv
// Sequential radix-4 Booth multiplier for 16x16 signed operands.
// It accepts one operand pair, generates one sign-inverted 18-bit partial
// product per cycle, and accumulates the weighted partial products into a
// 32-bit product. The sum starts from a bias that cancels the inverted sign bits.
// Ports:
//   sys_clk, sys_rst_n   : clock and synchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, B are two's complement)
//   out_valid / out_ready: product handshake (product is A*B, two's complement)
module booth4_seq_pp_accumulator #(
    parameter int unsigned N_PP   = 8,
    parameter logic [31:0] K_BIAS = 32'h5556_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product
);

    localparam int unsigned AW  = 16;
    localparam int unsigned PPW = 18;
    localparam int unsigned PW  = 32;
    localparam int unsigned CW  = 3;
    localparam logic [CW-1:0] LAST_PP = CW'(N_PP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   a_q, a_d;
    logic [AW-1:0]   b_q, b_d;
    logic [AW:0]     nega_q, nega_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [AW:0]     b_ext;
    logic [AW:0]     sexta;
    logic [4:0]      bit_idx;
    logic [2:0]      grp;
    logic [PPW-1:0]  pp;
    logic [PPW-1:0]  pp_s;
    logic [PW-1:0]   addend_c;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

    // Booth group decode for the current step; B[-1] is the appended zero.
    always_comb begin
        b_ext   = {b_q, 1'b0};
        sexta   = {a_q[AW-1], a_q};
        bit_idx = {1'b0, cnt_q, 1'b0};
        grp     = b_ext[bit_idx +: 3];
        pp      = '0;
        case (grp)
            3'b001, 3'b010: pp = {sexta[AW], sexta};
            3'b011:         pp = {sexta, 1'b0};
            3'b100:         pp = {nega_q, 1'b0};
            3'b101, 3'b110: pp = {nega_q[AW], nega_q};
            default:        pp = '0;
        endcase
        // Inverted sign bit makes the PP non-negative; K_BIAS removes the offset.
        pp_s     = {~pp[PPW-1], pp[PPW-2:0]};
        addend_c = PW'(pp_s) << bit_idx;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        nega_d    = nega_q;
        acc_d     = acc_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    nega_d  = (AW+1)'(0) - {A[AW-1], A};
                    acc_d   = K_BIAS;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + addend_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_PP) begin
                    product_d = acc_q + addend_c;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            nega_q      <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            nega_q      <= nega_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/booth4_seq_pp_accumulator.md
Name: booth4_seq_pp_accumulator

Overview:
- Sequential radix-4 Booth multiplier back end for the 16x16 signed multiplier.
- Accepts one operand pair (A, B) and generates one Booth partial product per cycle, in the 18-bit sign-inverted format used by the pp decoders.
- Accumulates the partial products with the correct weights into a 32-bit product.
- Serves as the low-area alternative to the Wallace-tree path, and as the golden-ish reference datapath for it.

Parameters:
- N_PP, 8, number of radix-4 partial products (fixed for 16-bit B; not intended to be changed)
- K_BIAS, 32'h5556_0000, accumulator preload; compensates the inverted sign bit of all 8 PPs

Ports:
- sys_clk  in  1  clock, all state updates on rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair on A/B is valid
- in_ready  out  1  block can accept an operand pair
- A  in  16  multiplicand, two's complement
- B  in  16  multiplier, two's complement
- out_valid  out  1  product is valid
- out_ready  in  1  consumer accepts product
- product  out  32  A*B, two's complement

Behaviour:
- Clocking and reset: one clock (sys_clk). Reset is synchronous and active-low (sys_rst_n sampled on the rising edge).
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, cnt=0, internal A/B/-A registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: register A and B, register negA = -sext17(A) (17 bits, so -(-32768)=+32768 is representable), set acc=K_BIAS, set cnt=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Group i=cnt uses bits {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0.
  - Selection by group value:
    - 000, 111 -> 0
    - 001, 010 -> +A
    - 011 -> +2A
    - 100 -> -2A
    - 101, 110 -> -A
  - PP is the 18-bit signed value; ±2A is formed by shifting sext17(A) or negA left by 1.
  - Sign-inverted form: pp_s = {~pp[17], pp[16:0]}.
  - Each edge: acc = acc + ({14'b0, pp_s} << 2*cnt), mod 2^32; cnt = cnt+1.
  - On the edge where cnt==7 (after the 8th add): product = final acc, go to DONE.
- DONE:
  - out_valid=1, product held stable.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - product keeps its last value after the transfer; it is only meaningful while out_valid=1.
- Correctness basis: K_BIAS = -(sum over i=0..7 of 2^(17+2i)) mod 2^32 = 0x5556_0000. The final acc therefore equals A*B mod 2^32, which is exact for 16x16 signed.
- Latency: the accepting edge is edge 0. out_valid rises after edge 8, so it is first visible in the cycle after 8 RUN edges.
- Throughput: a new pair is accepted no sooner than the edge after the DONE handshake, giving a minimum of 10 cycles per product.
- Boundary cases:
  - in_valid while busy is ignored (in_ready=0); the source must hold its data.
  - out_ready held low stalls indefinitely in DONE with product stable.
  - out_ready=1 already high on DONE entry: transfer completes on the first DONE edge.
  - Reset asserted mid-RUN or in DONE: abort, return to IDLE, discard the operation.
  - A=-32768 with code 011/100: ±2A = ∓65536, which fits in 18 bits.
  - Counter cnt is 3 bits; it wraps to 0 on the last add and is unused outside RUN.

Test Plan:
- A=16'h5C0B, B=16'h0003, accept, hold out_ready=1 -> out_valid rises 8 edges after acceptance, product=32'h0001_1421, IDLE one edge later.
- A=16'h8000, B=16'h8000 -> product=32'h4000_0000; A=16'h8000, B=16'h7FFF -> product=32'hC000_8000.
- A=16'hFFFF, B=16'hFFFF -> product=32'h0000_0001; A=16'h0000, B=16'h1234 -> product=32'h0000_0000.
- Backpressure:
  - A=16'h0007, B=16'hFFFE with out_ready=0 for 5 cycles in DONE -> product=32'hFFFF_FFF2 held stable, out_valid=1 throughout.
  - in_valid asserted with new operands during the stall -> ignored, in_ready=0.
- Reset mid-op: assert sys_rst_n=0 at RUN cnt=4 -> next edge: IDLE, in_ready=1, out_valid=0, product=0. Next operation A=16'h0002, B=16'h0003 -> product=32'h0000_0006.
- Randomised back-to-back: 10k random signed pairs with random in_valid/out_ready gaps -> every product equals $signed(A)*$signed(B). No accepted operand lost or duplicated; ordering preserved.
